// File: rtl/l1_cache_control_nway.sv
// N-way set-associative L1 cache control FSM: hit decode, victim selection, write-back and fill over L2.
// Optional saturating performance counters are built when L1_PERF_COUNTERS_EN is defined.
module l1_cache_control_nway #(
  parameter int WAYS      = 4,
  parameter int WAY_W     = $clog2(WAYS),
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 mem_read,
  input  logic                 mem_write,
  output logic                 mem_resp,
  input  logic [WAYS-1:0]      hit,
  input  logic [WAYS-1:0]      valid,
  input  logic [WAYS-1:0]      dirty,
  input  logic [WAY_W-1:0]     plru_victim,
  output logic                 load_plru,
  output logic [WAY_W-1:0]     plru_way,
  output logic [WAYS-1:0]      load_tag,
  output logic [WAYS-1:0]      load_valid,
  output logic [WAYS-1:0]      load_dirty,
  output logic                 valid_set,
  output logic                 dirty_set,
  output logic [WAY_W-1:0]     way_sel,
  output logic                 l2addr_sel,
  output logic                 l2_read,
  output logic                 l2_write,
  input  logic                 l2_resp,
`ifdef L1_PERF_COUNTERS_EN
  output logic [CNT_WIDTH-1:0] hit_count,
  output logic [CNT_WIDTH-1:0] miss_count,
  output logic [CNT_WIDTH-1:0] wb_count,
`endif
  output logic [1:0]           dbg_state
);

  // Handshake: a CPU request is valid only when exactly one of mem_read/mem_write is high;
  // mem_resp pulses for the one cycle the request is served. L2 strobes are held until l2_resp.
  typedef enum logic [1:0] {
    PROCESS    = 2'd0,
    WRITE_BACK = 2'd1,
    FETCH      = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [WAY_W-1:0]  victim_q, victim_d;

  logic              req;
  logic              any_hit;
  logic [WAY_W-1:0]  hit_way;
  logic              has_inv;
  logic [WAY_W-1:0]  inv_way;
  logic [WAY_W-1:0]  miss_victim;
  logic              victim_dirty;
  logic [WAYS-1:0]   victim_onehot;
  logic [WAYS-1:0]   hit_onehot;

  assign req     = mem_read ^ mem_write;
  assign any_hit = |hit;
  assign has_inv = ~&valid;

  // Lowest index wins for both the hit way and the first invalid way.
  always_comb begin
    hit_way = '0;
    inv_way = '0;
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (hit[i])   hit_way = WAY_W'(i);
      if (!valid[i]) inv_way = WAY_W'(i);
    end
  end

  assign miss_victim   = has_inv ? inv_way : plru_victim;
  assign victim_dirty  = valid[miss_victim] & dirty[miss_victim];
  assign victim_onehot = WAYS'(1) << victim_q;
  assign hit_onehot    = WAYS'(1) << hit_way;
  assign dbg_state     = state_q;

  always_comb begin
    state_d    = state_q;
    victim_d   = victim_q;
    mem_resp   = 1'b0;
    load_plru  = 1'b0;
    plru_way   = '0;
    load_tag   = '0;
    load_valid = '0;
    load_dirty = '0;
    valid_set  = 1'b0;
    dirty_set  = 1'b0;
    way_sel    = '0;
    l2addr_sel = 1'b0;
    l2_read    = 1'b0;
    l2_write   = 1'b0;
    case (state_q)
      PROCESS: begin
        if (req && any_hit) begin
          mem_resp  = 1'b1;
          way_sel   = hit_way;
          load_plru = 1'b1;
          plru_way  = hit_way;
          if (mem_write) begin
            load_tag   = hit_onehot;
            load_dirty = hit_onehot;
            dirty_set  = 1'b1;
          end
        end else if (req) begin
          victim_d = miss_victim;
          state_d  = victim_dirty ? WRITE_BACK : FETCH;
        end
      end
      WRITE_BACK: begin
        l2_write   = 1'b1;
        l2addr_sel = 1'b1;
        way_sel    = victim_q;
        if (l2_resp) state_d = FETCH;
      end
      FETCH: begin
        l2_read = 1'b1;
        // The fill completes even if the CPU has withdrawn its request.
        if (l2_resp) begin
          load_tag   = victim_onehot;
          load_valid = victim_onehot;
          load_dirty = victim_onehot;
          valid_set  = 1'b1;
          state_d    = PROCESS;
        end
      end
      default: state_d = PROCESS;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= PROCESS;
      victim_q <= '0;
    end else begin
      state_q  <= state_d;
      victim_q <= victim_d;
    end
  end

`ifdef L1_PERF_COUNTERS_EN
  logic miss_evt, wb_evt;
  assign miss_evt = (state_q == PROCESS) && (state_d != PROCESS);
  assign wb_evt   = (state_q == WRITE_BACK) && (state_d == FETCH);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_count  <= '0;
      miss_count <= '0;
      wb_count   <= '0;
    end else begin
      if (mem_resp && (hit_count != '1))  hit_count  <= hit_count + 1'b1;
      if (miss_evt && (miss_count != '1)) miss_count <= miss_count + 1'b1;
      if (wb_evt && (wb_count != '1))     wb_count   <= wb_count + 1'b1;
    end
  end
`endif

endmodule
